// File: rtl/coef_mux_arbiter_pkg.sv
// Shared types and constants for the coefficient mux arbiter.
package coef_mux_arbiter_pkg;

    localparam int unsigned NREQ = 4;
    localparam int unsigned SELW = 2;

    localparam logic [SELW-1:0] SEL_ONE = SELW'(1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_e;

endpackage

// File: rtl/coef_mux_arbiter_rr_pick4.sv
// Round-robin priority pick: first set request at or after ptr, wrapping modulo NREQ.
module rr_pick4
    import coef_mux_arbiter_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] owner,
    output logic            found
);

    logic [SELW-1:0] idx;

    // Scan ptr, ptr+1, ... with natural 2-bit wrap; the first hit wins.
    always_comb begin
        owner = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = ptr + k[SELW-1:0];
            if (!found && req[idx]) begin
                found = 1'b1;
                owner = idx;
            end
        end
    end

endmodule

// File: rtl/coef_mux_arbiter.sv
// Four-way burst-locking round-robin mux with a registered output slot.
module coef_mux_arbiter
    import coef_mux_arbiter_pkg::*;
#(
    parameter int unsigned DW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      req,
    input  logic [3:0]      last,
    input  logic [DW-1:0]   din_0,
    input  logic [DW-1:0]   din_1,
    input  logic [DW-1:0]   din_2,
    input  logic [DW-1:0]   din_3,
    output logic [3:0]      ack,
    output logic            o_valid,
    input  logic            o_ready,
    output logic [DW-1:0]   o_data,
    output logic [1:0]      o_src,
    output logic            o_last,
    output logic            busy
);

    state_e          state_q, state_d;
    logic [SELW-1:0] ptr_q, ptr_d;
    logic [SELW-1:0] owner_q, owner_d;
    logic            o_valid_q, o_valid_d;
    logic [DW-1:0]   o_data_q, o_data_d;
    logic [SELW-1:0] o_src_q, o_src_d;
    logic            o_last_q, o_last_d;

    logic [SELW-1:0] pick_owner;
    logic            pick_found;
    logic [DW-1:0]   din_sel;
    logic            slot_free;

    rr_pick4 u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .owner (pick_owner),
        .found (pick_found)
    );

    // Lane select for the current owner.
    always_comb begin
        case (owner_q)
            2'd0:    din_sel = din_0;
            2'd1:    din_sel = din_1;
            2'd2:    din_sel = din_2;
            default: din_sel = din_3;
        endcase
    end

    // FSM next state, ack generation and output-slot update.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        o_valid_d = o_valid_q;
        o_data_d  = o_data_q;
        o_src_d   = o_src_q;
        o_last_d  = o_last_q;
        ack       = '0;
        slot_free = !o_valid_q || o_ready;

        if (state_q == ST_LOCK && req[owner_q] && slot_free) begin
            ack[owner_q] = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    owner_d = pick_owner;
                    state_d = ST_LOCK;
                end
            end
            ST_LOCK: begin
                if (ack[owner_q] && last[owner_q]) begin
                    state_d = ST_IDLE;
                    ptr_d   = owner_q + SEL_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (ack != '0) begin
            o_valid_d = 1'b1;
            o_data_d  = din_sel;
            o_src_d   = owner_q;
            o_last_d  = last[owner_q];
        end else if (o_valid_q && o_ready) begin
            o_valid_d = 1'b0;
        end
    end

    // State and output registers, asynchronously cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            o_src_q   <= '0;
            o_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
            o_src_q   <= o_src_d;
            o_last_q  <= o_last_d;
        end
    end

    assign o_valid = o_valid_q;
    assign o_data  = o_data_q;
    assign o_src   = o_src_q;
    assign o_last  = o_last_q;
    assign busy    = (state_q == ST_LOCK);

endmodule
